// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore controller that sequences fetch, decode, execute,
// write-back and LDR/STR memory access for the simple RISC datapath.
// One instruction is in flight at a time; the IR is held after IF2.
//
// state    | meaning
// ---------+--------------------------------------------------------
// RST      | reset, PC forced to 0
// IF1      | instruction fetch, address from PC
// IF2      | instruction fetch, IR load
// UPD_PC   | PC <= PC + 1
// DECODE   | branch on {opcode,op}
// WR_IMM   | Rn <= sximm8
// GET_A    | A <= Rn
// GET_B    | B <= Rm
// EXEC     | C <= ALU result, or status flags for CMP
// WR_REG   | Rd <= C
// ADDR     | C <= Rn + sximm5 (effective address)
// LD_ADDR  | data address register <= C
// MEM_RD   | memory read, address from data address register
// LDR_WB   | Rd <= mdata
// STR_B    | B <= Rd
// STR_C    | C <= 0 + B (store data)
// STR_WR   | memory write
// HALT     | stopped until reset
module cpu_ctrl_fsm #(
  parameter logic [1:0] MEM_NONE  = 2'b00,
  parameter logic [1:0] MEM_READ  = 2'b01,
  parameter logic [1:0] MEM_WRITE = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_IF1     = 5'd1,
    S_IF2     = 5'd2,
    S_UPD_PC  = 5'd3,
    S_DECODE  = 5'd4,
    S_WR_IMM  = 5'd5,
    S_GET_A   = 5'd6,
    S_GET_B   = 5'd7,
    S_EXEC    = 5'd8,
    S_WR_REG  = 5'd9,
    S_ADDR    = 5'd10,
    S_LD_ADDR = 5'd11,
    S_MEM_RD  = 5'd12,
    S_LDR_WB  = 5'd13,
    S_STR_B   = 5'd14,
    S_STR_C   = 5'd15,
    S_STR_WR  = 5'd16,
    S_HALT    = 5'd17
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] instr;
  // Instruction class is latched in DECODE so EXEC/LD_ADDR outputs and
  // branches depend only on registered state (keeps the machine Moore).
  logic       is_cmp, is_mov_reg, is_str;

  assign instr = {opcode, op};

  // State register with asynchronous reset to RST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_nxt;
  end

  // Capture the instruction class while in DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_cmp     <= 1'b0;
      is_mov_reg <= 1'b0;
      is_str     <= 1'b0;
    end else if (state == S_DECODE) begin
      is_cmp     <= (instr == 5'b101_01);
      is_mov_reg <= (instr == 5'b110_00);
      is_str     <= (instr == 5'b100_00);
    end
  end

  // Next-state logic; unreachable encodings fall back to RST.
  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:     state_nxt = S_IF1;
      S_IF1:     state_nxt = S_IF2;
      S_IF2:     state_nxt = S_UPD_PC;
      S_UPD_PC:  state_nxt = S_DECODE;
      S_DECODE: begin
        casez (instr)
          5'b110_10: state_nxt = S_WR_IMM;
          5'b110_00: state_nxt = S_GET_B;
          5'b101_??: state_nxt = S_GET_A;
          5'b011_00: state_nxt = S_GET_A;
          5'b100_00: state_nxt = S_GET_A;
          5'b111_??: state_nxt = S_HALT;
          default:   state_nxt = S_IF1;
        endcase
      end
      S_WR_IMM:  state_nxt = S_IF1;
      S_GET_A:   state_nxt = (instr == 5'b011_00 || instr == 5'b100_00) ? S_ADDR : S_GET_B;
      S_GET_B:   state_nxt = S_EXEC;
      S_EXEC:    state_nxt = is_cmp ? S_IF1 : S_WR_REG;
      S_WR_REG:  state_nxt = S_IF1;
      S_ADDR:    state_nxt = S_LD_ADDR;
      S_LD_ADDR: state_nxt = is_str ? S_STR_B : S_MEM_RD;
      S_MEM_RD:  state_nxt = S_LDR_WB;
      S_LDR_WB:  state_nxt = S_IF1;
      S_STR_B:   state_nxt = S_STR_C;
      S_STR_C:   state_nxt = S_STR_WR;
      S_STR_WR:  state_nxt = S_IF1;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_RST;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    nsel      = 3'b000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPD_PC: load_pc = 1'b1;
      S_WR_IMM: begin
        nsel  = 3'b001;
        vsel  = 2'b10;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loads = is_cmp;
        loadc = !is_cmp;
        asel  = is_mov_reg;
      end
      S_WR_REG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = MEM_READ;
      S_LDR_WB: begin
        mem_cmd = MEM_READ;
        nsel    = 3'b010;
        vsel    = 2'b11;
        write   = 1'b1;
      end
      S_STR_B: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_STR_C: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_STR_WR: mem_cmd = MEM_WRITE;
      S_HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule
